// File: rtl/seq_mult_pkg.sv
// Shared types and helpers for the sequential shift-add multiplier.
package seq_mult_pkg;

  typedef logic [1:0] state_t;

  localparam state_t IDLE = 2'd0;
  localparam state_t BUSY = 2'd1;
  localparam state_t DONE = 2'd2;

  function automatic int unsigned prod_width(input int unsigned w);
    return 2 * w;
  endfunction

  function automatic int unsigned cnt_width(input int unsigned w);
    return int'($clog2(w)) + 1;
  endfunction

  // Magnitude of a w-bit value when tc is set, raw value otherwise.
  function automatic logic [63:0] abs_val(input logic [63:0] value, input int unsigned w,
                                          input logic tc);
    logic [63:0] mask;
    mask = (w >= 64) ? '1 : ((64'd1 << w) - 64'd1);
    if (tc && value[w-1]) begin
      return (~value + 64'd1) & mask;
    end
    return value & mask;
  endfunction

endpackage

// File: rtl/seq_mult_cneg.sv
// Conditional two's-complement negate: dout = neg ? -din : din.
module seq_mult_cneg #(
  parameter int unsigned W = 8
) (
  input  logic [W-1:0] din,
  input  logic         neg,
  output logic [W-1:0] dout
);

  assign dout = neg ? (~din + W'(1)) : din;

endmodule

// File: rtl/seq_mult.sv
// Sequential shift-add multiplier, one multiplier bit per clock, unsigned or signed per transaction.
// Define SEQ_MULT_EARLY_TERM_EN to finish as soon as the remaining multiplier bits are all zero.
module seq_mult
  import seq_mult_pkg::*;
#(
  parameter  int unsigned WIDTH = 8,
  localparam int unsigned CNT_W = cnt_width(WIDTH),
  localparam int unsigned PW    = prod_width(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             tc,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [PW-1:0]    product,
  output logic             busy
);

  state_t           state_q, state_d;
  logic [PW-1:0]    mcand_q, mcand_d;
  logic [PW-1:0]    acc_q, acc_d;
  logic [PW-1:0]    product_q, product_d;
  logic [WIDTH-1:0] mplier_q, mplier_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             neg_q, neg_d;

  logic [WIDTH-1:0] a_mag, b_mag;
  logic [PW-1:0]    acc_sum, acc_fix;
  logic [WIDTH-1:0] mplier_sh;
  logic [CNT_W-1:0] cnt_inc;
  logic             last_step;

  seq_mult_cneg #(.W(WIDTH)) u_abs_a (
    .din  (a),
    .neg  (tc & a[WIDTH-1]),
    .dout (a_mag)
  );

  seq_mult_cneg #(.W(WIDTH)) u_abs_b (
    .din  (b),
    .neg  (tc & b[WIDTH-1]),
    .dout (b_mag)
  );

  // Sign fix applied to the final partial sum on the last BUSY edge.
  seq_mult_cneg #(.W(PW)) u_sign_fix (
    .din  (acc_sum),
    .neg  (neg_q),
    .dout (acc_fix)
  );

  assign acc_sum   = mplier_q[0] ? (acc_q + mcand_q) : acc_q;
  assign mplier_sh = mplier_q >> 1;
  assign cnt_inc   = cnt_q + CNT_W'(1);

`ifdef SEQ_MULT_EARLY_TERM_EN
  assign last_step = (mplier_sh == '0) || (cnt_inc == CNT_W'(WIDTH));
`else
  assign last_step = (cnt_inc == CNT_W'(WIDTH));
`endif

  always_comb begin
    state_d   = state_q;
    mcand_d   = mcand_q;
    acc_d     = acc_q;
    product_d = product_q;
    mplier_d  = mplier_q;
    cnt_d     = cnt_q;
    neg_d     = neg_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          state_d  = BUSY;
          mcand_d  = {{WIDTH{1'b0}}, a_mag};
          mplier_d = b_mag;
          neg_d    = tc & (a[WIDTH-1] ^ b[WIDTH-1]);
          acc_d    = '0;
          cnt_d    = '0;
        end
      end
      BUSY: begin
        acc_d    = acc_sum;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_sh;
        cnt_d    = cnt_inc;
        if (last_step) begin
          state_d   = DONE;
          product_d = acc_fix;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      mcand_q   <= '0;
      acc_q     <= '0;
      product_q <= '0;
      mplier_q  <= '0;
      cnt_q     <= '0;
      neg_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      mcand_q   <= mcand_d;
      acc_q     <= acc_d;
      product_q <= product_d;
      mplier_q  <= mplier_d;
      cnt_q     <= cnt_d;
      neg_q     <= neg_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);
  assign product   = product_q;

endmodule

// File: tb/tb_seq_mult.sv
// Directed plus randomised bench for seq_mult with a product scoreboard.
module tb_seq_mult;

  localparam int unsigned WIDTH = 8;
`ifdef SEQ_MULT_EARLY_TERM_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif

  logic             clk, rst;
  logic             in_valid, in_ready, tc;
  logic             out_valid, out_ready, busy;
  logic [WIDTH-1:0] a, b;
  logic [2*WIDTH-1:0] product;

  int n_checks  = 0;
  int n_pass    = 0;
  int both_high = 0;
  logic [2*WIDTH-1:0] exp_q[$];

  seq_mult #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .tc        (tc),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .product   (product),
    .busy      (busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(negedge clk) begin
    if (in_ready && out_valid) both_high++;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    assert (got === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
  endtask

  function automatic logic [15:0] ref_prod(input logic [7:0] x, input logic [7:0] y,
                                           input logic s);
    int sx, sy;
    if (s) begin
      sx = int'($signed(x));
      sy = int'($signed(y));
    end else begin
      sx = int'(x);
      sy = int'(y);
    end
    return 16'(sx * sy);
  endfunction

  function automatic int ref_lat(input logic [7:0] y, input logic s);
    logic [7:0] m;
    int l;
    m = (s && y[7]) ? (~y + 8'd1) : y;
    l = 1;
    for (int i = 0; i < 8; i++) if (m[i]) l = i + 1;
    return EARLY ? l : int'(WIDTH);
  endfunction

  task automatic do_op(input logic [7:0] ta, input logic [7:0] tb_b, input logic ttc,
                       input int stall, input bit rnd_ready);
    logic [15:0] held, exp_p;
    int n, lat;
    a = ta; b = tb_b; tc = ttc; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    a = 8'($urandom); b = 8'($urandom); tc = 1'($urandom);
    exp_q.push_back(ref_prod(ta, tb_b, ttc));
    lat = ref_lat(tb_b, ttc);
    check("accept_flags", 64'({in_ready, busy}), 64'(2'b01));
    n = 0;
    do begin
      if (rnd_ready) out_ready = 1'($urandom);
      @(posedge clk); #1;
      n++;
    end while (!out_valid && n < 40);
    check("out_valid_rise", 64'(out_valid), 64'(1));
    check("latency", 64'(n), 64'(lat));
    held = product;
    for (int i = 0; i < stall; i++) begin
      out_ready = 1'b0;
      in_valid  = 1'($urandom);
      a = 8'($urandom); b = 8'($urandom);
      @(posedge clk); #1;
      check("hold_product", 64'(product), 64'(held));
      check("hold_flags", 64'({out_valid, in_ready}), 64'(2'b10));
    end
    in_valid = 1'b0;
    exp_p = exp_q.pop_front();
    check("product", 64'(product), 64'(exp_p));
    out_ready = 1'b1;
    @(posedge clk); #1;
    check("handshake", 64'({out_valid, in_ready, busy}), 64'(3'b010));
    out_ready = 1'b0;
  endtask

  initial begin
    in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; tc = 1'b0;
    rst = 1'b0;
    #1 rst = 1'b1;
    #2;
    check("reset_flags", 64'({in_ready, out_valid, busy}), 64'(3'b100));
    check("reset_product", 64'(product), 64'(0));
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk); #1;
    check("idle_hold", 64'({in_ready, busy}), 64'(2'b10));

    do_op(8'hFF, 8'hFF, 1'b0, 0, 1'b0);
    do_op(8'h80, 8'h80, 1'b1, 0, 1'b0);
    do_op(8'hFF, 8'h01, 1'b1, 0, 1'b0);
    do_op(8'hFF, 8'h01, 1'b0, 0, 1'b0);
    do_op(8'h00, 8'hFB, 1'b1, 0, 1'b0);
    do_op(8'h03, 8'h02, 1'b0, 0, 1'b0);
    do_op(8'h5A, 8'hC4, 1'b1, 5, 1'b0);

    // Abort an operation on its 4th BUSY cycle.
    a = 8'd9; b = 8'd200; tc = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("async_rst_flags", 64'({in_ready, out_valid, busy}), 64'(3'b100));
    check("async_rst_product", 64'(product), 64'(0));
    @(posedge clk); #1;
    rst = 1'b0;
    do_op(8'd7, 8'd6, 1'b0, 0, 1'b0);

    for (int k = 0; k < 1000; k++) begin
      do_op(8'($urandom), 8'($urandom), 1'($urandom), int'($urandom_range(0, 2)), 1'b1);
    end

    check("ready_valid_exclusive", 64'(both_high), 64'(0));
    check("scoreboard_empty", 64'(exp_q.size()), 64'(0));
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
